// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles every handshake and bus signal of alu_arbiter so the arbiter,
//   the requesting engines, the shared ALU and the response consumer all
//   attach through one object.
//
//   Parameters
//     WIDTH    operand/result width (must match the attached ALU)
//     NUM_REQ  number of requesters (2..8)
//     IDW      requester index width
//
//   Signal groups
//     req_*    per-requester valid/ready plus packed operands and op codes
//              (requester i owns bits [i*WIDTH +: WIDTH] / [i*3 +: 3])
//     alu_*    registered operands/op code to the ALU, result/carry back
//     rsp_*    single backpressured response channel tagged with rsp_id
//     busy     high while an operation is in flight or waiting to be taken
//
//   Modports
//     slave    the arbiter's view
//     master   the environment's view (requesters, ALU, consumer)
interface alu_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*3-1:0]     req_sel;

  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [2:0]               alu_sel;
  logic [WIDTH-1:0]         alu_out;
  logic                     alu_carry;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;

  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output rsp_valid, rsp_id, rsp_data, rsp_carry,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter/sequencer sharing one combinational ALU among
//   NUM_REQ requesters. One request is granted at a time: its operands are
//   registered onto the ALU inputs, the ALU result is captured one cycle
//   later and returned, tagged with the requester index, on a single
//   backpressured response channel. One operation takes at least three
//   cycles (IDLE accept, EXEC, RESP handshake).
//
//   Ports
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    alu_arbiter_if.slave: req_*, alu_*, rsp_*, busy
//
//   NUM_REQ is expected in 2..8 and IDW must equal $clog2(NUM_REQ).
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q;

  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [2:0]         alu_sel_q;

  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_carry_q;

  logic [IDW-1:0]     grant;
  logic               grant_found;
  logic               accept;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [2:0]         op_sel;

  // Round-robin search: rotate the valid vector so that index ptr lands at
  // bit 0, take the lowest set bit, then add ptr back modulo NUM_REQ.
  // Duplicating the vector makes the rotate a plain right shift.
  always_comb begin : arb_search
    logic [2*NUM_REQ-1:0] vld_dbl;
    logic [NUM_REQ-1:0]   vld_rot;
    logic [IDW:0]         off;
    logic [IDW:0]         sum;
    vld_dbl     = {bus.req_valid, bus.req_valid};
    vld_rot     = NUM_REQ'(vld_dbl >> ptr_q);
    off         = '0;
    grant_found = 1'b0;
    // Scan downward so the lowest offset is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        off         = (IDW+1)'(k);
        grant_found = 1'b1;
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    grant = sum[IDW-1:0];
  end

  // Operand/op-code slice of the granted requester.
  always_comb begin : payload_mux
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        a_sel  = bus.req_a[i*WIDTH +: WIDTH];
        b_sel  = bus.req_b[i*WIDTH +: WIDTH];
        op_sel = bus.req_sel[i*3 +: 3];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found;

  // Ready is gated by rst_n so nothing is offered while reset is held,
  // even though the state register already reads IDLE.
  assign bus.req_ready = (rst_n && accept)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant)
                       : '0;

  // FSM state and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          // Pointer moves only on accept, so idle cycles never skip anyone.
          ptr_d   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand registers: loaded on accept, held everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      id_q      <= '0;
    end else if (accept) begin
      alu_a_q   <= a_sel;
      alu_b_q   <= b_sel;
      alu_sel_q <= op_sel;
      id_q      <= grant;
    end
  end

  // Response registers: capture ALU result at the end of EXEC, hold in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= bus.alu_out;
        // Carry only means something for add (000) and sub (001).
        rsp_carry_q <= (alu_sel_q == 3'b000 || alu_sel_q == 3'b001)
                     ? bus.alu_carry : 1'b0;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed and randomized checks of alu_arbiter against a behavioural
//   model: grant = first valid index at or after a round-robin pointer
//   (modulo NUM_REQ), result = reference ALU function of the granted
//   operands, carry kept only for add/sub.
module tb_alu_arbiter;
  localparam int W   = 8;
  localparam int NR  = 4;
  localparam int IDW = $clog2(NR);

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  int ref_ptr  = 0;
  int last_acc = 0;

  alu_arbiter_if #(.WIDTH(W), .NUM_REQ(NR), .IDW(IDW)) bus ();

  alu_arbiter #(.WIDTH(W), .NUM_REQ(NR), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: add, sub (carry = borrow), and six logic/shift ops whose
  // carry output is driven high so the arbiter's masking is visible.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b1, a & b};
      3'd3:    return {1'b1, a | b};
      3'd4:    return {1'b1, a ^ b};
      3'd5:    return {1'b1, ~a};
      3'd6:    return {1'b1, a[6:0], 1'b0};
      default: return {1'b1, 1'b0, a[7:1]};
    endcase
  endfunction

  always_comb {bus.alu_carry, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ref_ptr + k) % NR;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_sel[i*3 +: 3] = s;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  32'(bus.req_ready), 32'h0);
    chk({tag, "_alu_a"},  32'(bus.alu_a), 32'h0);
    chk({tag, "_alu_b"},  32'(bus.alu_b), 32'h0);
    chk({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_id"},  32'(bus.rsp_id), 32'h0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'h0);
    chk({tag, "_rsp_carry"}, 32'(bus.rsp_carry), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  // One complete transaction starting in IDLE at +1 after an edge.
  // bp = cycles of rsp_ready low in RESP; drop = requester withdraws
  // valid once accepted.
  task automatic serve(input string tag, input int bp, input bit drop);
    int g;
    logic [7:0] ea, eb;
    logic [2:0] es;
    logic [8:0] r;
    logic       ec;
    g = model_grant();
    #1;
    if (g < 0) begin
      chk({tag, "_no_grant"}, 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
      return;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h1 << g);
    ea = bus.req_a[g*W +: W];
    eb = bus.req_b[g*W +: W];
    es = bus.req_sel[g*3 +: 3];
    @(posedge clk); #1;
    last_acc = cyc;
    ref_ptr  = (g + 1) % NR;
    if (drop) bus.req_valid[g] = 1'b0;
    if (bp > 0) bus.rsp_ready = 1'b0;
    chk({tag, "_exec_busy"}, 32'(bus.busy), 32'h1);
    chk({tag, "_exec_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_exec_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'(ea));
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'(eb));
    chk({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'(es));
    @(posedge clk); #1;
    r  = alu_fn(ea, eb, es);
    ec = (es == 3'd0 || es == 3'd1) ? r[8] : 1'b0;
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(g));
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(r[7:0]));
    chk({tag, "_rsp_carry"}, 32'(bus.rsp_carry), 32'(ec));
    chk({tag, "_resp_ready"}, 32'(bus.req_ready), 32'h0);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk({tag, "_bp_valid"}, 32'(bus.rsp_valid), 32'h1);
      chk({tag, "_bp_id"}, 32'(bus.rsp_id), 32'(g));
      chk({tag, "_bp_data"}, 32'(bus.rsp_data), 32'(r[7:0]));
      chk({tag, "_bp_ready"}, 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    logic [3:0] mask;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state: nothing offered even with a valid request present.
    bus.req_valid = 4'b0010;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    chk_all_zero("reset_hold");
    rst_n = 1'b1;
    ref_ptr = 0;
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Single request from requester 2: 0xF0 + 0x20.
    set_req(2, 8'hF0, 8'h20, 3'b000);
    bus.req_valid = 4'b0100;
    serve("add_r2", 0, 1'b1);

    // Subtract with borrow (ptr now 3).
    set_req(3, 8'h05, 8'h07, 3'b001);
    bus.req_valid = 4'b1000;
    serve("sub_borrow", 0, 1'b1);

    // AND: carry from the ALU must be masked.
    set_req(0, 8'hFF, 8'h01, 3'b010);
    bus.req_valid = 4'b0001;
    serve("and_mask", 0, 1'b1);

    // Bring ptr to 3, then requesters 1 and 3: 3 first, wrap, then 1.
    set_req(2, 8'h12, 8'h34, 3'b011);
    bus.req_valid = 4'b0100;
    serve("to_ptr3", 0, 1'b1);
    set_req(1, 8'h0F, 8'hF0, 3'b100);
    set_req(3, 8'h80, 8'h80, 3'b000);
    bus.req_valid = 4'b1010;
    chk("wrap_model_first", 32'(model_grant()), 32'd3);
    serve("wrap_r3", 0, 1'b1);
    chk("wrap_model_second", 32'(model_grant()), 32'd1);
    serve("wrap_r1", 0, 1'b1);

    // Backpressure: five cycles of rsp_ready low.
    set_req(2, 8'hA5, 8'h5A, 3'b001);
    bus.req_valid = 4'b0100;
    serve("backpressure", 5, 1'b1);

    // Fairness from a fresh reset: all four held valid.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < NR; i++) set_req(i, 8'(i * 16 + 3), 8'(i + 1), 3'(i));
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      chk("rr_order", 32'(model_grant()), 32'(n % NR));
      serve("rr", 0, 1'b0);
      if (n > 0) chk("rr_spacing", 32'(last_acc - prev), 32'd3);
      prev = last_acc;
    end

    // Asynchronous reset while in EXEC (ptr is 1 here; grant goes to 2).
    bus.req_valid = 4'b0100;
    set_req(2, 8'h11, 8'h22, 3'b000);
    #1;
    chk("arst_pre_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    chk("arst_in_exec", 32'(bus.busy), 32'h1);
    bus.req_valid = 4'b1000;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    #1;
    rst_n = 1'b1;
    ref_ptr = 0;
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("arst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    set_req(1, 8'h40, 8'h02, 3'b110);
    set_req(3, 8'h40, 8'h02, 3'b111);
    bus.req_valid = 4'b1010;
    chk("arst_model_from0", 32'(model_grant()), 32'd1);
    serve("arst_after", 0, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++)
        set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      bus.req_valid = mask;
      serve("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's N-bit ALU (3-bit op select, result plus carry-out) among NUM_REQ independent requesters. Each requester presents operands and an op code over a valid/ready handshake. The block grants one request at a time, registers the operands, drives the ALU and captures its result. It then returns the result, tagged with the requester index, on a single backpressured response channel. It sits between the requesting engines and the shared ALU datapath.

## Interface
- WIDTH, 8: operand/result width; must match the attached ALU.
- NUM_REQ, 4: number of requesters; 2..8.
- IDW, $clog2(NUM_REQ): width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing.
- req_sel  input  NUM_REQ*3  op code; requester i at [i*3 +: 3].
- alu_a, alu_b  output  WIDTH  registered operands to the ALU.
- alu_sel  output  3  registered op code to the ALU.
- alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
- alu_carry  input  1  ALU carry-out.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accept.
- rsp_id  output  IDW  index of the requester being answered.
- rsp_data  output  WIDTH  captured ALU result.
- rsp_carry  output  1  captured carry; meaningful for op 000 (add) and 001 (sub), forced 0 for all other ops.
- busy  output  1  high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Arbitration pointer ptr, IDW bits: the search starts at ptr and rises, wrapping at NUM_REQ-1 to 0.
- IDLE:
  - grant g is the first index with req_valid high, searched from ptr.
  - req_ready[g] = 1 combinationally; all other bits are 0.
  - If no valid request is present, all ready bits are 0 and the block stays in IDLE.
- Accept (IDLE and req_valid[g] and req_ready[g]):
  - alu_a, alu_b and alu_sel load from requester g's slices.
  - id_reg <= g.
  - ptr <= (g+1) mod NUM_REQ.
  - Next state is EXEC.
- EXEC, one cycle:
  - rsp_data <= alu_out and rsp_id <= id_reg.
  - rsp_carry <= alu_carry if alu_sel is 000 or 001, else 0.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data, rsp_id and rsp_carry hold stable until rsp_ready.
  - On rsp_ready, next state is IDLE.
- req_ready is 0 for every requester in EXEC and RESP.
- Requests are never queued. A requester is expected to hold valid and its payload until accepted, but a request withdrawn before grant is simply not served.
- alu_a, alu_b and alu_sel hold their last values outside EXEC.
- ptr advances only on accept, so an idle cycle never skips a requester.

## Timing
- Reset (rst_n low, asynchronous):
  - state is IDLE and ptr is 0.
  - alu_a, alu_b and alu_sel are 0.
  - rsp_valid, rsp_id, rsp_data, rsp_carry and busy are 0.
  - req_ready is all 0 while rst_n is low.
- Latency: accept at edge T, ALU evaluates during cycle T+1, rsp_valid is high from edge T+2.
- Best-case throughput is one operation per 3 cycles, with rsp_ready tied high.
- rsp_valid is registered. req_ready depends combinationally on req_valid and state only, never on rsp_ready.
- Simultaneous requests: exactly one is granted per accept. Every continuously valid requester is served within NUM_REQ grants.
- Backpressure: the block stays in RESP for as long as rsp_ready is low, with outputs frozen. The next accept can happen no earlier than the cycle after the rsp handshake.
- Reset asserted mid-operation, in EXEC or RESP: the in-flight result is discarded, no response is produced, and ptr returns to 0.

## Test plan
- Single request: requester 2 sends A=0xF0, B=0x20, sel=000 and is accepted at T. Required: rsp_valid at T+2 with rsp_id=2, rsp_data=0x10, rsp_carry=1.
- Subtract borrow and carry masking:
  - A=0x05, B=0x07, sel=001 gives rsp_data=0xFE, rsp_carry=1.
  - A=0xFF, B=0x01, sel=010 gives rsp_data=0x01, rsp_carry=0.
- Round-robin fairness: all 4 req_valid held high with ptr=0 after reset, rsp_ready=1. Required: grant order 0,1,2,3,0, one accept every 3 cycles.
- Pointer wrap and skip: with ptr=3, only requesters 1 and 3 valid. Required: 3 is granted first, ptr becomes 0, then 1 is granted.
- Backpressure: rsp_ready held low for 5 cycles in RESP. Required: rsp_valid stays high, data and id stay stable, req_ready stays all 0, and the next accept occurs the cycle after rsp_ready rises.
- Async reset mid-EXEC: rst_n pulsed low between edges. Required: all outputs go to 0 immediately, no rsp_valid follows, and the next grant searches from index 0.
